m_countdown_timer: RTL and testbench



---
 rtl/m_countdown_timer.sv | 195 +++++++++++++++++++
 tb/tb_m_countdown_timer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/m_countdown_timer.sv
// BCD mm:ss countdown timer with SET/RUN/PAUSE/ALARM control; M_COUNTDOWN_AUTO_RELOAD_EN adds a preset reloaded on alarm exit.
// Latency: every output is registered and changes one cycle after the causing input pulse.
// Backpressure: none; each input pulse is consumed on the cycle it is seen, lower-priority pulses in that cycle are dropped.
module m_countdown_timer #(
    parameter int ALARM_TICKS = 10,
    parameter int MAX_MIN     = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_tick,
    input  logic       i_start_stop,
    input  logic       i_inc_sec,
    input  logic       i_inc_min,
    input  logic       i_clear,
    output logic [3:0] o_min_h,
    output logic [3:0] o_min_l,
    output logic [3:0] o_sec_h,
    output logic [3:0] o_sec_l,
    output logic       o_running,
    output logic       o_alarm,
    output logic [1:0] o_state
);
    typedef enum logic [1:0] {
        ST_SET   = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_ALARM = 2'b11
    } state_t;

    localparam logic [3:0] MAX_MIN_H  = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_MIN_L  = 4'(MAX_MIN % 10);
    localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS);

    state_t     state_q, state_d;
    logic [3:0] min_h_q, min_l_q, sec_h_q, sec_l_q;
    logic [3:0] min_h_d, min_l_d, sec_h_d, sec_l_d;
    logic [3:0] dec_min_h, dec_min_l, dec_sec_h, dec_sec_l;
    logic [3:0] rl_min_h, rl_min_l, rl_sec_h, rl_sec_l;
    logic [7:0] alarm_cnt_q, alarm_cnt_d;
    logic       running_d, alarm_d;
    logic       time_zero, dec_zero;

    assign time_zero = ({min_h_q, min_l_q, sec_h_q, sec_l_q} == 16'd0);
    assign dec_zero  = ({dec_min_h, dec_min_l, dec_sec_h, dec_sec_l} == 16'd0);

`ifdef M_COUNTDOWN_AUTO_RELOAD_EN
    logic [15:0] preset_q, preset_d;

    always_comb begin
        preset_d = preset_q;
        if (i_clear)
            preset_d = 16'd0;
        else if (state_q == ST_SET && i_start_stop && !time_zero)
            preset_d = {min_h_q, min_l_q, sec_h_q, sec_l_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            preset_q <= 16'd0;
        else
            preset_q <= preset_d;
    end

    assign {rl_min_h, rl_min_l, rl_sec_h, rl_sec_l} = preset_q;
`else
    assign {rl_min_h, rl_min_l, rl_sec_h, rl_sec_l} = 16'd0;
`endif

    // One-second BCD decrement with borrow ripple; only used when time is non-zero.
    always_comb begin
        dec_sec_l = sec_l_q - 4'd1;
        dec_sec_h = sec_h_q;
        dec_min_l = min_l_q;
        dec_min_h = min_h_q;
        if (sec_l_q == 4'd0) begin
            dec_sec_l = 4'd9;
            dec_sec_h = sec_h_q - 4'd1;
            if (sec_h_q == 4'd0) begin
                dec_sec_h = 4'd5;
                dec_min_l = min_l_q - 4'd1;
                if (min_l_q == 4'd0) begin
                    dec_min_l = 4'd9;
                    dec_min_h = min_h_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SET;
            min_h_q     <= 4'd0;
            min_l_q     <= 4'd0;
            sec_h_q     <= 4'd0;
            sec_l_q     <= 4'd0;
            alarm_cnt_q <= 8'd0;
            o_running   <= 1'b0;
            o_alarm     <= 1'b0;
        end else begin
            state_q     <= state_d;
            min_h_q     <= min_h_d;
            min_l_q     <= min_l_d;
            sec_h_q     <= sec_h_d;
            sec_l_q     <= sec_l_d;
            alarm_cnt_q <= alarm_cnt_d;
            o_running   <= running_d;
            o_alarm     <= alarm_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        min_h_d     = min_h_q;
        min_l_d     = min_l_q;
        sec_h_d     = sec_h_q;
        sec_l_d     = sec_l_q;
        alarm_cnt_d = alarm_cnt_q;
        if (i_clear) begin
            state_d     = ST_SET;
            {min_h_d, min_l_d, sec_h_d, sec_l_d} = 16'd0;
            alarm_cnt_d = 8'd0;
        end else begin
            unique case (state_q)
                ST_SET: begin
                    if (i_start_stop) begin
                        if (!time_zero)
                            state_d = ST_RUN;
                    end else begin
                        if (i_inc_sec) begin
                            if (sec_h_q == 4'd5 && sec_l_q == 4'd9) begin
                                sec_h_d = 4'd0;
                                sec_l_d = 4'd0;
                            end else if (sec_l_q == 4'd9) begin
                                sec_h_d = sec_h_q + 4'd1;
                                sec_l_d = 4'd0;
                            end else begin
                                sec_l_d = sec_l_q + 4'd1;
                            end
                        end
                        if (i_inc_min) begin
                            if (min_h_q == MAX_MIN_H && min_l_q == MAX_MIN_L) begin
                                min_h_d = 4'd0;
                                min_l_d = 4'd0;
                            end else if (min_l_q == 4'd9) begin
                                min_h_d = min_h_q + 4'd1;
                                min_l_d = 4'd0;
                            end else begin
                                min_l_d = min_l_q + 4'd1;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (i_start_stop) begin
                        state_d = ST_PAUSE;
                    end else if (i_tick) begin
                        {min_h_d, min_l_d, sec_h_d, sec_l_d} = {dec_min_h, dec_min_l, dec_sec_h, dec_sec_l};
                        if (dec_zero) begin
                            state_d     = ST_ALARM;
                            alarm_cnt_d = 8'd0;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (i_start_stop)
                        state_d = ST_RUN;
                end
                ST_ALARM: begin
                    if (i_start_stop) begin
                        state_d = ST_SET;
                        {min_h_d, min_l_d, sec_h_d, sec_l_d} = {rl_min_h, rl_min_l, rl_sec_h, rl_sec_l};
                    end else if (i_tick) begin
                        alarm_cnt_d = alarm_cnt_q + 8'd1;
                        if (alarm_cnt_d == ALARM_LAST) begin
                            state_d = ST_SET;
                            {min_h_d, min_l_d, sec_h_d, sec_l_d} = {rl_min_h, rl_min_l, rl_sec_h, rl_sec_l};
                        end
                    end
                end
                default: state_d = ST_SET;
            endcase
        end
    end

    always_comb begin
        running_d = (state_d == ST_RUN);
        alarm_d   = (state_d == ST_ALARM);
    end

    assign o_state = state_q;
    assign o_min_h = min_h_q;
    assign o_min_l = min_l_q;
    assign o_sec_h = sec_h_q;
    assign o_sec_l = sec_l_q;
endmodule

// File: tb/tb_m_countdown_timer.sv
// Bench for m_countdown_timer: integer-seconds model checked every cycle plus directed literal expectations.
module tb_m_countdown_timer;
    localparam int AT = 10;
    localparam int MM = 59;
`ifdef M_COUNTDOWN_AUTO_RELOAD_EN
    localparam int RELOAD = 1;
`else
    localparam int RELOAD = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       i_tick = 1'b0, i_start_stop = 1'b0, i_inc_sec = 1'b0, i_inc_min = 1'b0, i_clear = 1'b0;
    logic [3:0] o_min_h, o_min_l, o_sec_h, o_sec_l;
    logic       o_running, o_alarm;
    logic [1:0] o_state;

    int n_cmp = 0;
    int n_err = 0;

    // Model: state code, time as minutes/seconds integers, alarm ticks seen, preset in seconds.
    int m_st = 0, m_min = 0, m_sec = 0, m_cnt = 0, m_pre = 0, tot = 0;

    m_countdown_timer #(.ALARM_TICKS(AT), .MAX_MIN(MM)) dut (
        .clk(clk), .rst_n(rst_n), .i_tick(i_tick), .i_start_stop(i_start_stop),
        .i_inc_sec(i_inc_sec), .i_inc_min(i_inc_min), .i_clear(i_clear),
        .o_min_h(o_min_h), .o_min_l(o_min_l), .o_sec_h(o_sec_h), .o_sec_l(o_sec_l),
        .o_running(o_running), .o_alarm(o_alarm), .o_state(o_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0; m_min = 0; m_sec = 0; m_cnt = 0; m_pre = 0;
        end else if (i_clear) begin
            m_st = 0; m_min = 0; m_sec = 0; m_cnt = 0; m_pre = 0;
        end else if (i_start_stop) begin
            case (m_st)
                0: if (m_min * 60 + m_sec != 0) begin m_st = 1; m_pre = m_min * 60 + m_sec; end
                1: m_st = 2;
                2: m_st = 1;
                default: begin
                    m_st = 0;
                    m_min = RELOAD ? m_pre / 60 : 0;
                    m_sec = RELOAD ? m_pre % 60 : 0;
                end
            endcase
        end else if (i_tick && m_st == 1) begin
            tot = m_min * 60 + m_sec - 1;
            m_min = tot / 60;
            m_sec = tot % 60;
            if (tot == 0) begin m_st = 3; m_cnt = 0; end
        end else if (i_tick && m_st == 3) begin
            m_cnt++;
            if (m_cnt == AT) begin
                m_st = 0;
                m_min = RELOAD ? m_pre / 60 : 0;
                m_sec = RELOAD ? m_pre % 60 : 0;
            end
        end else if (m_st == 0) begin
            if (i_inc_sec) m_sec = (m_sec + 1) % 60;
            if (i_inc_min) m_min = (m_min + 1) % (MM + 1);
        end
    end

    always @(negedge clk) begin
        check("state", int'(o_state), m_st);
        check("min_h", int'(o_min_h), m_min / 10);
        check("min_l", int'(o_min_l), m_min % 10);
        check("sec_h", int'(o_sec_h), m_sec / 10);
        check("sec_l", int'(o_sec_l), m_sec % 10);
        check("running", int'(o_running), (m_st == 1) ? 1 : 0);
        check("alarm", int'(o_alarm), (m_st == 3) ? 1 : 0);
    end

    task automatic drv(input logic c, input logic s, input logic t, input logic is, input logic im, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            i_clear = c; i_start_stop = s; i_tick = t; i_inc_sec = is; i_inc_min = im;
        end
        @(posedge clk); #1;
        i_clear = 0; i_start_stop = 0; i_tick = 0; i_inc_sec = 0; i_inc_min = 0;
    endtask

    task automatic lit(input string name, input int st, input int mh, input int ml, input int sh, input int sl);
        @(negedge clk);
        check({name, ".state"}, int'(o_state), st);
        check({name, ".time"}, int'({o_min_h, o_min_l, o_sec_h, o_sec_l}), (mh << 12) | (ml << 8) | (sh << 4) | sl);
    endtask

    initial begin
        int ph;
        ph = $urandom_range(1, 4);
        #(ph);
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        lit("reset", 0, 0, 0, 0, 0);
        check("reset.alarm", int'(o_alarm), 0);
        check("reset.running", int'(o_running), 0);

        drv(0, 0, 0, 1, 0, 61);
        drv(0, 0, 0, 0, 1, 3);
        lit("set_wrap", 0, 0, 3, 0, 1);
        drv(0, 0, 0, 1, 1, 1);
        lit("both_inc", 0, 0, 4, 0, 2);
        drv(1, 0, 0, 0, 0, 1);
        drv(0, 1, 0, 0, 0, 1);
        lit("start_at_zero", 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 1, 60);
        lit("min_wrap", 0, 0, 0, 0, 0);

        drv(0, 0, 0, 0, 1, 10);
        drv(0, 1, 0, 0, 0, 1);
        drv(0, 0, 1, 0, 0, 1);
        lit("borrow", 1, 0, 9, 5, 9);
        drv(0, 0, 1, 0, 0, 599);
        lit("to_alarm", 3, 0, 0, 0, 0);
        check("to_alarm.alarm", int'(o_alarm), 1);
        drv(0, 0, 1, 0, 0, AT - 1);
        lit("alarm_hold", 3, 0, 0, 0, 0);
        drv(0, 0, 1, 0, 0, 1);
        lit("alarm_timeout", 0, RELOAD, 0, 0, 0);
        check("alarm_timeout.alarm", int'(o_alarm), 0);

        drv(1, 0, 0, 0, 0, 1);
        drv(0, 0, 0, 0, 1, 1);
        drv(0, 0, 0, 1, 0, 35);
        drv(0, 1, 0, 0, 0, 1);
        drv(0, 0, 1, 0, 0, 5);
        lit("run_0130", 1, 0, 1, 3, 0);
        drv(0, 1, 1, 0, 0, 1);
        lit("pause_prio", 2, 0, 1, 3, 0);
        drv(0, 0, 1, 1, 1, 4);
        lit("pause_frozen", 2, 0, 1, 3, 0);
        drv(0, 1, 0, 0, 0, 1);
        lit("resume", 1, 0, 1, 3, 0);

        drv(1, 0, 0, 0, 0, 1);
        drv(0, 0, 0, 1, 0, 5);
        drv(0, 1, 0, 0, 0, 1);
        drv(0, 0, 1, 0, 0, 5);
        lit("alarm2", 3, 0, 0, 0, 0);
        drv(0, 0, 1, 0, 0, 2);
        drv(0, 1, 0, 0, 0, 1);
        lit("ack", 0, 0, 0, 0, RELOAD * 5);
        drv(0, 1, 0, 0, 0, 1);
        lit("restart", RELOAD, 0, 0, 0, RELOAD * 5);
        drv(1, 0, 0, 0, 0, 1);
        lit("clear", 0, 0, 0, 0, 0);
        drv(0, 0, 0, 1, 0, 3);
        drv(0, 1, 0, 0, 0, 1);
        drv(0, 0, 1, 0, 0, 1);
        drv(1, 0, 0, 0, 0, 1);
        lit("clear_in_run", 0, 0, 0, 0, 0);

        drv(0, 0, 0, 1, 0, 5);
        drv(0, 1, 0, 0, 0, 1);
        drv(0, 0, 1, 0, 0, 2);
        @(posedge clk);
        #3 rst_n = 0;
        lit("mid_reset", 0, 0, 0, 0, 0);
        check("mid_reset.running", int'(o_running), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        drv(0, 1, 0, 0, 0, 1);
        lit("post_reset", 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
